// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master side is the hazard controller, the slave side is the pipeline
// (stage registers, PC and the data-memory port).
interface pipeline_hazard_ctrl_if #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int CNT_WIDTH        = 16
);
    logic [REG_NUM_BITWIDTH-1:0] id_rs1;
    logic [REG_NUM_BITWIDTH-1:0] id_rs2;
    logic                        id_useRs1;
    logic                        id_useRs2;
    logic                        ex_memRead;
    logic [REG_NUM_BITWIDTH-1:0] ex_regToWrite;
    logic                        mem_PCSrc;
    logic                        mem_memRead;
    logic                        mem_memWrite;
    logic                        dmem_ready;

    logic                        dmem_req;
    logic                        pc_stall;
    logic                        if_id_stall;
    logic                        if_id_flush;
    logic                        id_ex_flush;
    logic                        ex_mem_stall;
    logic                        ex_mem_flush;
    logic                        mem_wb_bubble;
    logic                        mem_err;
    logic [CNT_WIDTH-1:0]        stall_count;
    logic [CNT_WIDTH-1:0]        flush_count;

    modport master (
        input  id_rs1, id_rs2, id_useRs1, id_useRs2,
        input  ex_memRead, ex_regToWrite,
        input  mem_PCSrc, mem_memRead, mem_memWrite, dmem_ready,
        output dmem_req, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
        output ex_mem_stall, ex_mem_flush, mem_wb_bubble, mem_err,
        output stall_count, flush_count
    );

    modport slave (
        output id_rs1, id_rs2, id_useRs1, id_useRs2,
        output ex_memRead, ex_regToWrite,
        output mem_PCSrc, mem_memRead, mem_memWrite, dmem_ready,
        input  dmem_req, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
        input  ex_mem_stall, ex_mem_flush, mem_wb_bubble, mem_err,
        input  stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RISC-V pipeline.
// Handles load-use stalls, taken-branch flushes resolved in MEM and
// data-memory wait states, with a sticky timeout error and saturating
// stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int MEM_TIMEOUT      = 16,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.master bus
);
    localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t                      state;
    logic [WCW-1:0]              waitCnt;
    logic                        memErr;
    logic [CNT_WIDTH-1:0]        stallCount;
    logic [CNT_WIDTH-1:0]        flushCount;

    logic                        memop;
    logic                        loadUse;
    logic [REG_NUM_BITWIDTH-1:0] exRd;

    logic dmemReq, pcStall, ifIdStall, ifIdFlush, idExFlush;
    logic exMemStall, exMemFlush, memWbBubble;

    // Hazard qualifiers shared by the output decode and the state update.
    always_comb begin
        exRd    = bus.ex_regToWrite;
        memop   = bus.mem_memRead | bus.mem_memWrite;
        loadUse = bus.ex_memRead && (exRd != '0) &&
                  ((bus.id_useRs1 && (bus.id_rs1 == exRd)) ||
                   (bus.id_useRs2 && (bus.id_rs2 == exRd)));
    end

    // Control outputs decoded from state and inputs; memory wait beats a
    // branch flush, which beats a load-use stall. Everything is low in reset.
    always_comb begin
        dmemReq     = 1'b0;
        pcStall     = 1'b0;
        ifIdStall   = 1'b0;
        ifIdFlush   = 1'b0;
        idExFlush   = 1'b0;
        exMemStall  = 1'b0;
        exMemFlush  = 1'b0;
        memWbBubble = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    dmemReq = memop;
                    if (memop && !bus.dmem_ready) begin
                        pcStall     = 1'b1;
                        ifIdStall   = 1'b1;
                        exMemStall  = 1'b1;
                        memWbBubble = 1'b1;
                    end else if (bus.mem_PCSrc) begin
                        ifIdFlush  = 1'b1;
                        idExFlush  = 1'b1;
                        exMemFlush = 1'b1;
                    end else if (loadUse) begin
                        pcStall   = 1'b1;
                        ifIdStall = 1'b1;
                        idExFlush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    dmemReq = 1'b1;
                    if (!bus.dmem_ready) begin
                        pcStall     = 1'b1;
                        ifIdStall   = 1'b1;
                        exMemStall  = 1'b1;
                        memWbBubble = 1'b1;
                    end
                end
                ERROR: begin
                    pcStall     = 1'b1;
                    ifIdStall   = 1'b1;
                    exMemStall  = 1'b1;
                    memWbBubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Memory-wait sequencer: counts wait cycles and traps into ERROR on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memop && !bus.dmem_ready) begin
                        state   <= MEM_WAIT;
                        waitCnt <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        state <= RUN;
                    end else if (waitCnt == WAIT_LAST) begin
                        state  <= ERROR;
                        memErr <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + WCW'(1);
                    end
                end
                ERROR:   state <= ERROR;
                default: state <= RUN;
            endcase
        end
    end

    // Saturating performance counters for stalled cycles and branch flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (pcStall && (stallCount != '1))
                stallCount <= stallCount + CNT_WIDTH'(1);
            if (ifIdFlush && (flushCount != '1))
                flushCount <= flushCount + CNT_WIDTH'(1);
        end
    end

    // Drive the bundle outputs.
    always_comb begin
        bus.dmem_req      = dmemReq;
        bus.pc_stall      = pcStall;
        bus.if_id_stall   = ifIdStall;
        bus.if_id_flush   = ifIdFlush;
        bus.id_ex_flush   = idExFlush;
        bus.ex_mem_stall  = exMemStall;
        bus.ex_mem_flush  = exMemFlush;
        bus.mem_wb_bubble = memWbBubble;
        bus.mem_err       = memErr;
        bus.stall_count   = stallCount;
        bus.flush_count   = flushCount;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a table of single-cycle
// decode vectors plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;
    localparam int RNB = 5;
    localparam int CNTW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipeline_hazard_ctrl_if #(.REG_NUM_BITWIDTH(RNB), .CNT_WIDTH(CNTW)) bus ();

    pipeline_hazard_ctrl #(
        .REG_NUM_BITWIDTH(RNB),
        .MEM_TIMEOUT(4),
        .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    // Expected-control bit order: req, pcStall, ifIdStall, ifIdFlush,
    // idExFlush, exMemStall, exMemFlush, memWbBubble.
    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_LU     = 8'b0110_1000;
    localparam logic [7:0] C_BR     = 8'b0001_1010;
    localparam logic [7:0] C_REQ    = 8'b1000_0000;
    localparam logic [7:0] C_WAIT   = 8'b1110_0101;
    localparam logic [7:0] C_REQBR  = 8'b1001_1010;
    localparam logic [7:0] C_REQLU  = 8'b1110_1000;
    localparam logic [7:0] C_ERR    = 8'b0110_0101;

    typedef struct {
        logic [RNB-1:0] rs1;
        logic [RNB-1:0] rs2;
        logic           use1;
        logic           use2;
        logic           exMemRead;
        logic [RNB-1:0] exRd;
        logic           pcSrc;
        logic           memRead;
        logic           memWrite;
        logic           ready;
        logic [7:0]     expCtl;
    } vec_t;

    vec_t vecs[11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [RNB-1:0] rs1, input logic [RNB-1:0] rs2,
                                   input logic use1, input logic use2,
                                   input logic exMemRead, input logic [RNB-1:0] exRd,
                                   input logic pcSrc, input logic memRead,
                                   input logic memWrite, input logic ready,
                                   input logic [7:0] expCtl);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
        v.exMemRead = exMemRead; v.exRd = exRd; v.pcSrc = pcSrc;
        v.memRead = memRead; v.memWrite = memWrite; v.ready = ready;
        v.expCtl = expCtl;
        return v;
    endfunction

    function automatic logic [7:0] getCtl();
        return {bus.dmem_req, bus.pc_stall, bus.if_id_stall, bus.if_id_flush,
                bus.id_ex_flush, bus.ex_mem_stall, bus.ex_mem_flush, bus.mem_wb_bubble};
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.id_rs1        = v.rs1;
        bus.id_rs2        = v.rs2;
        bus.id_useRs1     = v.use1;
        bus.id_useRs2     = v.use2;
        bus.ex_memRead    = v.exMemRead;
        bus.ex_regToWrite = v.exRd;
        bus.mem_PCSrc     = v.pcSrc;
        bus.mem_memRead   = v.memRead;
        bus.mem_memWrite  = v.memWrite;
        bus.dmem_ready    = v.ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulseReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic stepTo(input vec_t v);
        @(negedge clk);
        applyStimulus(v);
        #1;
    endtask

    vec_t idle, luVec, brLuVec, stWait, stWaitBr, stDoneBr, brOnly, ldWait, ldReady;
    int   reqCycles;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        vecs[0]  = mkVec(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, C_NONE);
        vecs[1]  = mkVec(5'd5, 5'd1, 1, 1, 1, 5'd5, 0, 0, 0, 0, C_LU);
        vecs[2]  = mkVec(5'd2, 5'd5, 1, 1, 1, 5'd5, 0, 0, 0, 0, C_LU);
        vecs[3]  = mkVec(5'd5, 5'd1, 0, 1, 1, 5'd5, 0, 0, 0, 0, C_NONE);
        vecs[4]  = mkVec(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, 0, C_NONE);
        vecs[5]  = mkVec(5'd5, 5'd5, 1, 1, 0, 5'd5, 0, 0, 0, 0, C_NONE);
        vecs[6]  = mkVec(5'd5, 5'd1, 1, 0, 1, 5'd5, 1, 0, 0, 0, C_BR);
        vecs[7]  = mkVec(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, C_REQ);
        vecs[8]  = mkVec(5'd5, 5'd1, 1, 0, 1, 5'd5, 1, 0, 1, 0, C_WAIT);
        vecs[9]  = mkVec(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 1, 1, C_REQBR);
        vecs[10] = mkVec(5'd7, 5'd9, 0, 1, 1, 5'd9, 0, 1, 0, 1, C_REQLU);

        idle     = vecs[0];
        luVec    = mkVec(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, C_LU);
        brLuVec  = vecs[6];
        stWait   = mkVec(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, C_WAIT);
        stWaitBr = mkVec(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 1, 0, C_WAIT);
        stDoneBr = mkVec(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 1, 1, C_REQ);
        brOnly   = mkVec(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, C_BR);
        ldWait   = mkVec(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, C_WAIT);
        ldReady  = mkVec(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, C_ERR);

        // Reset state: outputs forced low even with a stalling input pattern.
        applyStimulus(ldWait);
        @(negedge clk);
        #1;
        checkOutput("reset_ctl", 32'(getCtl()), 32'(C_NONE));
        checkOutput("reset_stallCnt", 32'(bus.stall_count), 0);
        checkOutput("reset_flushCnt", 32'(bus.flush_count), 0);
        checkOutput("reset_memErr", 32'(bus.mem_err), 0);
        applyStimulus(idle);
        rst = 1'b0;

        // Single-cycle decode table, each vector from a fresh RUN state.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_ctl", i), 32'(getCtl()), 32'(vecs[i].expCtl));
            applyStimulus(idle);
            pulseReset();
        end

        // Load-use: one stall cycle, counted once.
        stepTo(luVec);
        checkOutput("lu_ctl", 32'(getCtl()), 32'(C_LU));
        stepTo(idle);
        checkOutput("lu_after_ctl", 32'(getCtl()), 32'(C_NONE));
        checkOutput("lu_stallCnt", 32'(bus.stall_count), 1);
        pulseReset();

        // Branch overrides load-use; one flush event.
        stepTo(brLuVec);
        checkOutput("br_ctl", 32'(getCtl()), 32'(C_BR));
        stepTo(idle);
        checkOutput("br_flushCnt", 32'(bus.flush_count), 1);
        checkOutput("br_stallCnt", 32'(bus.stall_count), 0);
        pulseReset();

        // Store with three wait cycles; branch held in frozen EX/MEM is
        // only acted on once back in RUN.
        reqCycles = 0;
        stepTo(stWait);
        checkOutput("st_c1_ctl", 32'(getCtl()), 32'(C_WAIT));
        reqCycles += int'(bus.dmem_req);
        stepTo(stWaitBr);
        checkOutput("st_c2_ctl", 32'(getCtl()), 32'(C_WAIT));
        reqCycles += int'(bus.dmem_req);
        stepTo(stWaitBr);
        checkOutput("st_c3_ctl", 32'(getCtl()), 32'(C_WAIT));
        reqCycles += int'(bus.dmem_req);
        stepTo(stDoneBr);
        checkOutput("st_done_ctl", 32'(getCtl()), 32'(C_REQ));
        reqCycles += int'(bus.dmem_req);
        stepTo(brOnly);
        checkOutput("st_br_ctl", 32'(getCtl()), 32'(C_BR));
        checkOutput("st_reqCycles", 32'(reqCycles), 4);
        checkOutput("st_stallCnt", 32'(bus.stall_count), 3);
        checkOutput("st_flushCnt0", 32'(bus.flush_count), 0);
        stepTo(idle);
        checkOutput("st_flushCnt1", 32'(bus.flush_count), 1);
        checkOutput("st_memErr", 32'(bus.mem_err), 0);
        pulseReset();

        // Timeout: four stall cycles then ERROR, which ignores a late ready.
        for (int c = 1; c <= 4; c++) begin
            stepTo(ldWait);
            checkOutput($sformatf("to_c%0d_ctl", c), 32'(getCtl()), 32'(C_WAIT));
            checkOutput($sformatf("to_c%0d_memErr", c), 32'(bus.mem_err), 0);
        end
        stepTo(ldReady);
        checkOutput("to_err_ctl", 32'(getCtl()), 32'(C_ERR));
        checkOutput("to_err_memErr", 32'(bus.mem_err), 1);
        checkOutput("to_err_stallCnt", 32'(bus.stall_count), 4);
        for (int k = 0; k < 15; k++) begin
            stepTo(ldReady);
        end
        checkOutput("to_hold_ctl", 32'(getCtl()), 32'(C_ERR));
        checkOutput("to_sat_stallCnt", 32'(bus.stall_count), 15);
        applyStimulus(idle);
        rst = 1'b1;
        #1;
        checkOutput("to_rst_memErr", 32'(bus.mem_err), 0);
        checkOutput("to_rst_stallCnt", 32'(bus.stall_count), 0);
        rst = 1'b0;
        #1;
        checkOutput("to_rst_ctl", 32'(getCtl()), 32'(C_NONE));

        // Reset during MEM_WAIT returns to RUN with nothing carried over.
        stepTo(ldWait);
        stepTo(ldWait);
        checkOutput("mw_ctl", 32'(getCtl()), 32'(C_WAIT));
        rst = 1'b1;
        #1;
        checkOutput("mw_rst_ctl", 32'(getCtl()), 32'(C_NONE));
        checkOutput("mw_rst_stallCnt", 32'(bus.stall_count), 0);
        @(posedge clk);
        #1;
        checkOutput("mw_rst_hold_ctl", 32'(getCtl()), 32'(C_NONE));
        applyStimulus(idle);
        rst = 1'b0;
        stepTo(brOnly);
        checkOutput("mw_run_ctl", 32'(getCtl()), 32'(C_BR));

        // Flush counter saturates at all-ones.
        for (int k = 0; k < 19; k++) begin
            stepTo(brOnly);
        end
        stepTo(idle);
        checkOutput("fl_sat_flushCnt", 32'(bus.flush_count), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
